// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register file geometry,
// FSM encoding and the default per-register outstanding-write limit.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RegAddrBus     = 5;
    localparam int unsigned RegNum         = 32;
    localparam int unsigned MaxInflightDef = 3;
    localparam int unsigned InflightW      = 4;

    typedef logic [RegAddrBus-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register outstanding-write counters with pending lookup for both source
// operands, a full flag for the destination and a saturating total.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MaxInflight = MaxInflightDef,
    parameter bit          WbBypass    = 1'b1,
    parameter int unsigned NRegs       = RegNum
) (
    input  logic                 clk,
    input  logic                 rst,
    input  reg_addr_t            rs1_addr_i,
    input  reg_addr_t            rs2_addr_i,
    input  reg_addr_t            rd_addr_i,
    input  logic                 inc_en_i,
    input  logic                 wb_wd_i,
    input  reg_addr_t            wb_wreg_i,
    output logic                 pend1_o,
    output logic                 pend2_o,
    output logic                 rd_full_o,
    output logic [InflightW-1:0] inflight_o
);

    localparam int unsigned CntW = $clog2(MaxInflight + 1);

    logic [CntW-1:0] cnt_q [NRegs];
    logic [CntW-1:0] cnt_d [NRegs];
    logic [CntW-1:0] c1, c2, crd, cwb;
    logic [15:0]     sum;

    // x0 is never counted, so its slot reads as zero and never pends.
    always_comb begin
        c1  = '0;
        c2  = '0;
        crd = '0;
        cwb = '0;
        for (int i = 1; i < NRegs; i++) begin
            if (rs1_addr_i == RegAddrBus'(i)) c1  = cnt_q[i];
            if (rs2_addr_i == RegAddrBus'(i)) c2  = cnt_q[i];
            if (rd_addr_i  == RegAddrBus'(i)) crd = cnt_q[i];
            if (wb_wreg_i  == RegAddrBus'(i)) cwb = cnt_q[i];
        end
    end

    assign pend1_o   = (c1 != '0) &&
                       !(WbBypass && wb_wd_i && (wb_wreg_i == rs1_addr_i) && (c1 == CntW'(1)));
    assign pend2_o   = (c2 != '0) &&
                       !(WbBypass && wb_wd_i && (wb_wreg_i == rs2_addr_i) && (c2 == CntW'(1)));
    assign rd_full_o = (crd == CntW'(MaxInflight));

    always_comb begin
        logic inc, dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < NRegs; i++) begin
            inc      = inc_en_i && (i != 0) && (rd_addr_i == RegAddrBus'(i));
            // Retiring an idle register is dropped rather than wrapping.
            dec      = wb_wd_i && (i != 0) && (wb_wreg_i == RegAddrBus'(i)) &&
                       (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i] + CntW'(inc) - CntW'(dec);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NRegs; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NRegs; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 1; i < NRegs; i++) sum = sum + 16'(cnt_q[i]);
    end

    assign inflight_o = (sum > 16'd15) ? '1 : sum[InflightW-1:0];

    retire_without_write : assert property (
        @(posedge clk) disable iff (!rst)
        !(wb_wd_i && (wb_wreg_i != '0) && (cwb == '0))
    ) else $error("retire of a register with no outstanding write");

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller beside the ID stage: holds pc/if_id and bubbles ID/EX while a
// source is pending, and drains all outstanding writes after a flush request.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MaxInflight = MaxInflightDef,
    parameter bit          WbBypass    = 1'b1,
    parameter int unsigned NRegs       = RegNum
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic                  id_reg1_read_i,
    input  logic [RegAddrBus-1:0] id_reg1_addr_i,
    input  logic                  id_reg2_read_i,
    input  logic [RegAddrBus-1:0] id_reg2_addr_i,
    input  logic                  id_wd_i,
    input  logic [RegAddrBus-1:0] id_wreg_i,
    input  logic                  wb_wd_i,
    input  logic [RegAddrBus-1:0] wb_wreg_i,
    input  logic                  flush_req_i,
    output logic                  pc_wd_o,
    output logic                  ifid_wd_o,
    output logic                  idex_bubble_o,
    output logic                  issue_o,
    output logic [1:0]            state_o,
    output logic [InflightW-1:0]  inflight_o
);

    state_e state_q, state_d;
    logic   pend1, pend2, rd_full, hazard;

    hazard_scoreboard #(
        .MaxInflight (MaxInflight),
        .WbBypass    (WbBypass),
        .NRegs       (NRegs)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (id_reg1_addr_i),
        .rs2_addr_i (id_reg2_addr_i),
        .rd_addr_i  (id_wreg_i),
        .inc_en_i   (issue_o && id_wd_i),
        .wb_wd_i    (wb_wd_i),
        .wb_wreg_i  (wb_wreg_i),
        .pend1_o    (pend1),
        .pend2_o    (pend2),
        .rd_full_o  (rd_full),
        .inflight_o (inflight_o)
    );

    assign hazard  = (id_reg1_read_i && pend1) || (id_reg2_read_i && pend2) ||
                     (id_wd_i && rd_full);
    assign issue_o = rst && id_valid_i && !hazard && (state_q != StDrain) && !flush_req_i;
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StRun;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun, StStall: begin
                if (flush_req_i) state_d = StDrain;
                else if (hazard) state_d = StStall;
                else             state_d = StRun;
            end
            // Leave only once the drained count has been observed at zero.
            StDrain: if (inflight_o == '0) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_wd_o       = 1'b1;
        ifid_wd_o     = 1'b1;
        idex_bubble_o = !issue_o;
        if (!rst || (state_q == StDrain) || hazard) begin
            pc_wd_o       = 1'b0;
            ifid_wd_o     = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model of the
// scoreboard and pipeline control rules.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wd_i, wb_wd_i, flush_req_i;
    logic [4:0] id_reg1_addr_i, id_reg2_addr_i, id_wreg_i, wb_wreg_i;
    logic       pc_wd_o, ifid_wd_o, idex_bubble_o, issue_o;
    logic [1:0] state_o;
    logic [3:0] inflight_o;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt  [32];
    int nx_cnt [32];
    int m_state;
    int nx_state;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_wd_i        (id_wd_i),
        .id_wreg_i      (id_wreg_i),
        .wb_wd_i        (wb_wd_i),
        .wb_wreg_i      (wb_wreg_i),
        .flush_req_i    (flush_req_i),
        .pc_wd_o        (pc_wd_o),
        .ifid_wd_o      (ifid_wd_o),
        .idex_bubble_o  (idex_bubble_o),
        .issue_o        (issue_o),
        .state_o        (state_o),
        .inflight_o     (inflight_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit m_pend(input int r);
        return (r != 0) && (m_cnt[r] != 0) &&
               !(wb_wd_i && (int'(wb_wreg_i) == r) && (m_cnt[r] == 1));
    endfunction

    // Reference model: expected outputs from the current model state and inputs.
    always @(negedge clk) begin
        bit h, iss, stalled;
        int sum, infl;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i]  = 0;
                nx_cnt[i] = 0;
            end
            m_state  = 0;
            nx_state = 0;
            check("m_rst_pc", pc_wd_o, 0);
            check("m_rst_ifid", ifid_wd_o, 0);
            check("m_rst_bubble", idex_bubble_o, 1);
            check("m_rst_issue", issue_o, 0);
            check("m_rst_state", state_o, 0);
            check("m_rst_inflight", inflight_o, 0);
        end else begin
            h = (id_reg1_read_i && m_pend(int'(id_reg1_addr_i))) ||
                (id_reg2_read_i && m_pend(int'(id_reg2_addr_i))) ||
                (id_wd_i && m_cnt[id_wreg_i] == 3);
            iss = id_valid_i && !h && (m_state != 2) && !flush_req_i;
            sum = 0;
            for (int i = 1; i < 32; i++) sum += m_cnt[i];
            infl    = (sum > 15) ? 15 : sum;
            stalled = (m_state == 2) || h;
            check("m_pc_wd", pc_wd_o, !stalled);
            check("m_ifid_wd", ifid_wd_o, !stalled);
            check("m_bubble", idex_bubble_o, stalled || !iss);
            check("m_issue", issue_o, iss);
            check("m_state", state_o, m_state);
            check("m_inflight", inflight_o, infl);
            nx_cnt = m_cnt;
            if (wb_wd_i && wb_wreg_i != 0 && m_cnt[wb_wreg_i] > 0) nx_cnt[wb_wreg_i]--;
            if (iss && id_wd_i && id_wreg_i != 0) nx_cnt[id_wreg_i]++;
            if (m_state == 2)     nx_state = (infl == 0) ? 0 : 2;
            else if (flush_req_i) nx_state = 2;
            else if (h)           nx_state = 1;
            else                  nx_state = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = nx_cnt;
            m_state = nx_state;
        end
    end

    task automatic step(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                        input bit wd, input int rd, input bit wb, input int wr, input bit fl);
        @(posedge clk);
        #1;
        id_valid_i     = v;
        id_reg1_read_i = r1e;
        id_reg1_addr_i = 5'(r1);
        id_reg2_read_i = r2e;
        id_reg2_addr_i = 5'(r2);
        id_wd_i        = wd;
        id_wreg_i      = 5'(rd);
        wb_wd_i        = wb;
        wb_wreg_i      = 5'(wr);
        flush_req_i    = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int rd);
        step(1, 0, 0, 0, 0, 1, rd, 0, 0, 0);
    endtask

    task automatic rd1(input int r);
        step(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input int r);
        step(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    task automatic set_rst(input bit v);
        @(posedge clk);
        #1;
        rst = v;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        {id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wd_i, wb_wd_i, flush_req_i} = '0;
        {id_reg1_addr_i, id_reg2_addr_i, id_wreg_i, wb_wreg_i} = '0;

        // Reset held: outputs forced to the stalled pattern.
        idle();
        check("rst_pc", pc_wd_o, 0);
        check("rst_bubble", idex_bubble_o, 1);
        check("rst_issue", issue_o, 0);
        set_rst(1);
        check("post_rst_state", state_o, 0);
        check("post_rst_pc", pc_wd_o, 1);

        // Reset mid-operation discards tracking.
        wr(5);
        check("x5_issue", issue_o, 1);
        check("x5_bubble", idex_bubble_o, 0);
        wr(5);
        idle();
        check("x5_inflight", inflight_o, 2);
        set_rst(0);
        check("midrst_inflight", inflight_o, 0);
        check("midrst_pc", pc_wd_o, 0);
        check("midrst_state", state_o, 0);
        set_rst(1);
        check("relrst_inflight", inflight_o, 0);

        // x0 is neither tracked nor stalled on.
        wr(0);
        check("x0_wr_issue", issue_o, 1);
        rd1(0);
        check("x0_rd_pc", pc_wd_o, 1);
        check("x0_rd_issue", issue_o, 1);
        idle();
        check("x0_inflight", inflight_o, 0);

        // RAW on x3, released in the retire cycle through the bypass.
        wr(3);
        rd1(3);
        check("raw_pc", pc_wd_o, 0);
        check("raw_bubble", idex_bubble_o, 1);
        check("raw_state_run", state_o, 0);
        rd1(3);
        check("raw_state_stall", state_o, 1);
        check("raw_hold_pc", pc_wd_o, 0);
        step(1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
        check("raw_bypass_pc", pc_wd_o, 1);
        check("raw_bypass_issue", issue_o, 1);
        check("raw_bypass_state", state_o, 1);
        idle();
        check("raw_back_run", state_o, 0);
        check("raw_inflight", inflight_o, 0);

        // Same-cycle issue and retire of x7.
        wr(7);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        check("x7_same_issue", issue_o, 1);
        idle();
        check("x7_inflight", inflight_o, 1);
        retire(7);
        idle();
        check("x7_cleared", inflight_o, 0);

        // Per-register saturation on x9.
        wr(9);
        wr(9);
        wr(9);
        idle();
        check("x9_inflight3", inflight_o, 3);
        wr(9);
        check("x9_full_pc", pc_wd_o, 0);
        check("x9_full_issue", issue_o, 0);
        wr(9);
        check("x9_full_state", state_o, 1);
        step(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        check("x9_retire_still_full", pc_wd_o, 0);
        wr(9);
        check("x9_resume_issue", issue_o, 1);
        retire(9);
        retire(9);
        retire(9);
        idle();
        check("x9_drained", inflight_o, 0);
        check("x9_state_run", state_o, 0);

        // Flush with two writes in flight.
        wr(4);
        wr(6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fl_req_state", state_o, 0);
        check("fl_req_issue", issue_o, 0);
        idle();
        check("fl_drain_state", state_o, 2);
        check("fl_drain_pc", pc_wd_o, 0);
        check("fl_drain_ifid", ifid_wd_o, 0);
        check("fl_drain_bubble", idex_bubble_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fl_drain_no_issue", issue_o, 0);
        retire(4);
        check("fl_r4_state", state_o, 2);
        retire(6);
        check("fl_r6_inflight", inflight_o, 1);
        idle();
        check("fl_zero_inflight", inflight_o, 0);
        check("fl_zero_state", state_o, 2);
        idle();
        check("fl_exit_state", state_o, 0);
        check("fl_exit_pc", pc_wd_o, 1);

        // Total saturates at 15.
        for (int r = 10; r < 16; r++) begin
            for (int k = 0; k < 3; k++) wr(r);
        end
        idle();
        check("sat_inflight", inflight_o, 15);
        retire(10);
        idle();
        check("sat_after_retire", inflight_o, 15);
        set_rst(0);
        check("sat_rst_inflight", inflight_o, 0);
        set_rst(1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
